// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 (low half) multiply sequencer driving the shared ALU via req/gnt.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq #(
  parameter int          WIDTH   = 16,
  parameter int          CNT_W   = 5,
  parameter logic [3:0]  CMD_ADD = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic             step_en;
  logic [WIDTH-1:0] next_acc;

  // A step with a set multiplier bit needs the ALU; otherwise it proceeds alone.
  always_comb begin
    alu_req  = (state == RUN) && mplier[0];
    step_en  = (state == RUN) && (!mplier[0] || alu_gnt);
    next_acc = mplier[0] ? alu_result : acc;
    alu_a    = alu_req ? acc   : '0;
    alu_b    = alu_req ? mcand : '0;
    alu_cmd  = CMD_ADD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef MUL_EARLY_EXIT_EN
          if (mplier == '0) begin
            product <= acc;
            done    <= 1'b1;
            state   <= DONE;
          end else
`endif
          if (step_en) begin
            acc    <= next_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              product <= next_acc;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: expected product/latency queued at start, checked on done.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        alu_req;
  logic        alu_gnt;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_cmd;
  logic [15:0] alu_result;

  typedef struct {
    logic [15:0] prod;
    int unsigned t0;
    int unsigned lat;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int unsigned cyc = 0;
  int unsigned stall_left = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_mul_seq #(.WIDTH(16), .CNT_W(5), .CMD_ADD(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cmd    (alu_cmd),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural ALU: add, carry dropped.
  assign alu_result = alu_a + alu_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle on which done is seen, counting the accepting edge as cycle 0.
  function automatic int unsigned exp_lat(input logic [15:0] b, input int unsigned stalls);
    int unsigned steps;
    steps = 0;
    for (int i = 0; i < 16; i++) if (b[i]) steps = i + 1;
`ifdef MUL_EARLY_EXIT_EN
    return ((steps == 16) ? 17 : steps + 2) + stalls;
`else
    return 17 + stalls;
`endif
  endfunction

  // Grant model: deny the first stall_left requested cycles, grant otherwise.
  always @(negedge clk) begin
    if (alu_req && stall_left > 0) begin
      alu_gnt = 1'b0;
      stall_left--;
      check_eq("stall_hold_a", alu_a, 16'h0000);
      check_eq("stall_hold_b", alu_b, op_a);
    end else begin
      alu_gnt = 1'b1;
    end
  end

  // Monitor: interface sanity every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    sb_entry_t e;
    if (!rst) begin
      check_eq("busy_vs_ready", busy, !ready);
      if (alu_req) begin
        check_eq("alu_cmd", alu_cmd, 4'b0000);
      end else begin
        check_eq("alu_a_quiet", alu_a, 16'h0000);
        check_eq("alu_b_quiet", alu_b, 16'h0000);
      end
      if (done) begin
        check_eq("done_busy", busy, 1'b1);
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", done, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check_eq("product", product, e.prod);
          check_eq("latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input int unsigned stalls);
    sb_entry_t e;
    @(negedge clk);
    check_eq("ready_before_start", ready, 1'b1);
    op_a       = a;
    op_b       = b;
    start      = 1'b1;
    stall_left = (b != 0) ? stalls : 0;
    e.prod     = a * b;
    e.t0       = cyc;
    e.lat      = exp_lat(b, (b != 0) ? stalls : 0);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after start_op (first RUN cycle) with the grant always given.
  task automatic check_req_pattern(input logic [15:0] b);
    logic [15:0] bv;
    int unsigned steps;
    bv    = b;
    steps = 16;
`ifdef MUL_EARLY_EXIT_EN
    steps = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) steps = i + 1;
`endif
    for (int i = 0; i < 16; i++) begin
      if (i < steps) begin
        check_eq("req_step", alu_req, bv[i]);
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (!(ready && !done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_wait", ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    sb_entry_t   e;
    logic [15:0] ra;
    logic [15:0] rb;
    int unsigned rs;

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_product", product, 16'h0000);
    check_eq("rst_req", alu_req, 1'b0);
    check_eq("rst_alu_a", alu_a, 16'h0000);
    check_eq("rst_alu_b", alu_b, 16'h0000);
    check_eq("rst_cmd", alu_cmd, 4'b0000);
    rst = 1'b0;

    start_op(16'd3, 16'd5, 0);
    check_req_pattern(16'd5);
    wait_idle();

    start_op(16'hFFFF, 16'hFFFF, 0);
    check_req_pattern(16'hFFFF);
    wait_idle();

    start_op(16'h1234, 16'h0003, 4);
    wait_idle();

    // Start during RUN must be ignored.
    start_op(16'd2, 16'd3, 0);
    op_a  = 16'd7;
    op_b  = 16'd9;
    start = 1'b1;
    @(negedge clk);
    check_eq("busy_start_ready", ready, 1'b0);
    start = 1'b0;
    wait_idle();

    // Start held through done: ignored in the done cycle, accepted the cycle after.
    start_op(16'd2, 16'd3, 0);
    op_a  = 16'd7;
    op_b  = 16'd9;
    start = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("held_start_done", done, 1'b1);
    @(negedge clk);
    check_eq("held_start_ready", ready, 1'b1);
    e.prod = 16'd63;
    e.t0   = cyc;
    e.lat  = exp_lat(16'd9, 0);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check_eq("held_start_busy", busy, 1'b1);
    wait_idle();

    // Reset in RUN cycle 8: back to reset state, no done pulse.
    start_op(16'h1234, 16'h00FF, 0);
    repeat (7) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_eq("midrst_ready", ready, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_req", alu_req, 1'b0);
    check_eq("midrst_product", product, 16'h0000);
    check_eq("midrst_done", done, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start_op(16'h0101, 16'h0011, 0);
    wait_idle();

    start_op(16'h5A5A, 16'h0000, 0);
    wait_idle();
    start_op(16'hBEEF, 16'h0001, 0);
    wait_idle();
    start_op(16'h8001, 16'h8000, 0);
    wait_idle();

    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = $urandom_range(0, 3);
      if (rs != 0) rb[0] = 1'b1;
      start_op(ra, rb, rs);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
